// File: rtl/fifo_pkg.sv
// fifo_pkg: geometry and pointer type shared by the FIFO read- and write-pointer blocks
package fifo_pkg;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int PTR_W  = ADDR_W + 1;
    typedef logic [PTR_W-1:0] ptr_t;
endpackage

// File: rtl/read_pointer_valid_pipe.sv
// valid_pipe: LAT-stage shift register aligning a read enable to RAM data; LAT=0 passes straight through
module valid_pipe #(
    parameter int LAT = 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_d,
    output logic o_q
);
    if (LAT == 0) begin : g_pass
        assign o_q = i_d;
    end else begin : g_pipe
        logic [LAT-1:0] r_sr;
        // Reset flushes in-flight reads so no stale strobe leaks out after release
        always_ff @(posedge CLK or negedge RST)
            if (!RST) r_sr <= '0;
            else      r_sr <= (r_sr << 1) | LAT'(i_d);
        assign o_q = r_sr[LAT-1];
    end
endmodule

// File: rtl/read_pointer.sv
// read_pointer: read-side pointer, status flags, fill count and data-valid strobe of the single-clock FIFO
module read_pointer
    import fifo_pkg::*;
#(
    parameter int MEM_LAT   = 1,
    parameter int AE_THRESH = 4,
    parameter int AF_THRESH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             RD_EN,
    input  logic             CLR_ERR,
    input  logic [PTR_W-1:0] WR_PTR,
    output logic [PTR_W-1:0] RD_PTR,
    output logic             RE,
    output logic             Empty,
    output logic             Full,
    output logic             Almost_Empty,
    output logic             Almost_Full,
    output logic [PTR_W-1:0] Fill_Count,
    output logic             RD_VALID,
    output logic             Underflow
);
    ptr_t r_rd_ptr;
    logic r_underflow;
    ptr_t w_fill;
    logic w_empty;
    logic w_re;

    assign w_fill  = WR_PTR - r_rd_ptr;
    assign w_empty = WR_PTR == r_rd_ptr;
    assign w_re    = RD_EN & ~w_empty;

    // Pointer advances on each granted read; the MSB toggles on every wrap of the address
    always_ff @(posedge CLK or negedge RST)
        if (!RST)      r_rd_ptr <= '0;
        else if (w_re) r_rd_ptr <= r_rd_ptr + 1'b1;

    // Sticky underflow; a new underflow outranks a clear in the same cycle
    always_ff @(posedge CLK or negedge RST)
        if (!RST) r_underflow <= 1'b0;
        else      r_underflow <= (RD_EN & w_empty) | (r_underflow & ~CLR_ERR);

    valid_pipe #(.LAT(MEM_LAT)) u_valid_pipe (
        .CLK (CLK),
        .RST (RST),
        .i_d (w_re),
        .o_q (RD_VALID)
    );

    assign RD_PTR       = r_rd_ptr;
    assign RE           = w_re;
    assign Empty        = w_empty;
    assign Full         = (WR_PTR[ADDR_W] != r_rd_ptr[ADDR_W]) && (WR_PTR[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
    assign Almost_Empty = w_fill <= PTR_W'(AE_THRESH);
    assign Almost_Full  = w_fill >= PTR_W'(DEPTH - AF_THRESH);
    assign Fill_Count   = w_fill;
    assign Underflow    = r_underflow;
endmodule

// File: tb/tb_read_pointer.sv
// tb_read_pointer: scoreboard bench for read_pointer with a modelled writer and RAM
module tb_read_pointer;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rd_en = 1'b0, clr = 1'b0, wr_en = 1'b0;
    logic [7:0] wdata = '0;
    logic [8:0] wr_ptr;
    logic [8:0] rd_ptr, fc;
    logic       re, empty, full, ae, af, rd_valid, uf;
    logic [7:0] mem [256];
    logic [7:0] rdata;
    logic [7:0] exp_q [$];
    int         n_tests = 0, n_fail = 0;

    logic       rst2 = 1'b0, rd_en2 = 1'b0;
    logic [8:0] wr_ptr2 = '0;
    logic [8:0] rd_ptr2, fc2;
    logic       re2, empty2, full2, ae2, af2, valid2, uf2;

    always #5 clk = ~clk;

    read_pointer #(.MEM_LAT(1)) u_dut (
        .CLK(clk), .RST(rst), .RD_EN(rd_en), .CLR_ERR(clr), .WR_PTR(wr_ptr),
        .RD_PTR(rd_ptr), .RE(re), .Empty(empty), .Full(full), .Almost_Empty(ae),
        .Almost_Full(af), .Fill_Count(fc), .RD_VALID(rd_valid), .Underflow(uf)
    );

    read_pointer #(.MEM_LAT(2)) u_lat2 (
        .CLK(clk), .RST(rst2), .RD_EN(rd_en2), .CLR_ERR(1'b0), .WR_PTR(wr_ptr2),
        .RD_PTR(rd_ptr2), .RE(re2), .Empty(empty2), .Full(full2), .Almost_Empty(ae2),
        .Almost_Full(af2), .Fill_Count(fc2), .RD_VALID(valid2), .Underflow(uf2)
    );

    always @(posedge clk or negedge rst)
        if (!rst) wr_ptr <= '0;
        else if (wr_en) begin
            mem[wr_ptr[7:0]] <= wdata;
            wr_ptr <= wr_ptr + 1'b1;
        end

    always @(posedge clk)
        if (re) rdata <= mem[rd_ptr[7:0]];

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, a, e, $time);
        end
    endtask

    always @(negedge clk)
        if (rst && rd_valid) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_valid_unexpected: got valid with data %0d, required no valid", rdata);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (rdata !== e) begin
                    n_fail++;
                    $display("FAIL rd_data: got %0d expected %0d at %0t", rdata, e, $time);
                end
            end
        end

    task automatic push_wr(input int k);
        wr_en = 1'b1;
        wdata = 8'(k) ^ 8'h5A;
        exp_q.push_back(wdata);
    endtask

    initial begin
        logic [8:0] exp_rp;
        logic       crossed;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        rst2 = 1'b1;
        #1;
        chk("rst_rd_ptr", rd_ptr, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_fill", fc, 0);
        chk("rst_ae", ae, 1);
        chk("rst_af", af, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_uf", uf, 0);

        rd_en = 1'b1;
        #1;
        chk("t1_re_blocked", re, 0);
        @(negedge clk);
        rd_en = 1'b0;
        clr = 1'b1;
        #1;
        chk("t1_uf_set", uf, 1);
        chk("t1_empty", empty, 1);
        chk("t1_ptr_hold", rd_ptr, 0);
        @(negedge clk);
        clr = 1'b0;
        #1;
        chk("t1_uf_clr", uf, 0);

        for (int k = 0; k < 3; k++) begin
            push_wr(k);
            @(negedge clk);
        end
        wr_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rd_en = 1'b1;
            #1;
            chk("t2_re", re, k < 3);
            chk("t2_rd_ptr", rd_ptr, k < 3 ? k : 3);
            chk("t2_valid", rd_valid, k >= 1);
            chk("t2_uf_low", uf, 0);
            @(negedge clk);
        end
        rd_en = 1'b0;
        clr = 1'b1;
        #1;
        chk("t2_uf_set", uf, 1);
        chk("t2_valid_end", rd_valid, 0);
        chk("t2_rd_ptr_end", rd_ptr, 3);
        @(negedge clk);
        clr = 1'b0;

        for (int i = 1; i <= 256; i++) begin
            push_wr(i);
            @(negedge clk);
            wr_en = 1'b0;
            #1;
            chk("t3_fill", fc, i);
            chk("t3_ae", ae, i <= 4);
            chk("t3_af", af, i >= 252);
            chk("t3_full", full, i == 256);
            chk("t3_empty", empty, 0);
        end
        rd_en = 1'b1;
        #1;
        chk("t3_re_full", re, 1);
        @(negedge clk);
        rd_en = 1'b0;
        #1;
        chk("t3_full_drop", full, 0);
        chk("t3_fill_255", fc, 255);
        chk("t3_af_255", af, 1);

        for (int i = 0; i < 251; i++) begin
            rd_en = 1'b1;
            @(negedge clk);
        end
        rd_en = 1'b0;
        #1;
        chk("t5_fill_start", fc, 4);
        for (int i = 0; i < 10; i++) begin
            push_wr(1000 + i);
            rd_en = 1'b1;
            @(negedge clk);
            #1;
            chk("t5_fill_hold", fc, 4);
            chk("t5_ae", ae, 1);
        end
        wr_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd_en = 1'b1;
            @(negedge clk);
        end
        rd_en = 1'b0;
        #1;
        chk("t5_drained", empty, 1);
        chk("t5_rd_ptr", rd_ptr, 269);

        exp_rp = 9'd269;
        crossed = 1'b0;
        for (int c = 0; c <= 600; c++) begin
            wr_en = 1'b0;
            if (c < 600) push_wr(2000 + c);
            rd_en = c > 0;
            #1;
            chk("t4_rd_ptr", rd_ptr, exp_rp);
            chk("t4_empty", empty, c == 0);
            chk("t4_full", full, 0);
            chk("t4_re", re, c > 0);
            if (rd_ptr == 9'd511) crossed = 1'b1;
            @(negedge clk);
            if (c > 0) exp_rp = exp_rp + 1'b1;
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        #1;
        chk("t4_crossed_wrap", crossed, 1);
        chk("t4_fill_end", fc, 0);
        chk("t4_empty_end", empty, 1);
        chk("t4_rd_ptr_end", rd_ptr, 357);
        chk("t4_uf", uf, 0);
        repeat (3) @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);

        wr_ptr2 = 9'd2;
        rd_en2 = 1'b1;
        #1;
        chk("l2_re", re2, 1);
        @(negedge clk);
        rd_en2 = 1'b0;
        #1;
        chk("l2_valid_c1", valid2, 0);
        chk("l2_rd_ptr", rd_ptr2, 1);
        @(negedge clk);
        #1;
        chk("l2_valid_c2", valid2, 1);
        @(negedge clk);
        #1;
        chk("l2_valid_c3", valid2, 0);
        rd_en2 = 1'b1;
        #1;
        chk("t6_re", re2, 1);
        @(negedge clk);
        rd_en2 = 1'b0;
        rst2 = 1'b0;
        wr_ptr2 = '0;
        #1;
        chk("t6_rst_ptr", rd_ptr2, 0);
        chk("t6_rst_valid", valid2, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("t6_in_rst_valid", valid2, 0);
        end
        @(negedge clk);
        rst2 = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("t6_post_valid", valid2, 0);
            chk("t6_post_ptr", rd_ptr2, 0);
            chk("t6_post_empty", empty2, 1);
            @(negedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
